// File: rtl/wb_slave_regs_pkg.sv
// Shared definitions for the Wishbone register slave: register map, FSM states
// and the byte-lane merge helper.
package wb_slave_pkg;

  localparam int REG_CTRL       = 0;
  localparam int REG_INT_STATUS = 1;
  localparam int REG_INT_MASK   = 2;
  localparam int REG_ID         = 3;
  localparam int REG_GEN_BASE   = 4;

  // apply_sel works on the widest supported word; callers cast to DATA_W.
  localparam int WORD_MAX_W = 64;
  localparam int SEL_MAX_W  = WORD_MAX_W / 8;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} wb_state_e;

  function automatic logic [WORD_MAX_W-1:0] apply_sel(
    input logic [WORD_MAX_W-1:0] old_v,
    input logic [WORD_MAX_W-1:0] new_v,
    input logic [SEL_MAX_W-1:0]  sel
  );
    logic [WORD_MAX_W-1:0] r;
    r = old_v;
    for (int unsigned b = 0; b < SEL_MAX_W; b++) begin
      if (sel[b]) r[8*b +: 8] = new_v[8*b +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/wb_slave_regs_if.sv
// Wishbone B3 classic bus bundle; signal names are from the slave's viewpoint.
interface wb_slave_regs_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) ();
  logic [ADDR_W-1:0]   wb_adr_i;
  logic [DATA_W-1:0]   wb_dat_i;
  logic [DATA_W/8-1:0] wb_sel_i;
  logic                wb_we_i;
  logic                wb_cyc_i;
  logic                wb_stb_i;
  logic [DATA_W-1:0]   wb_dat_o;
  logic                wb_ack_o;
  logic                wb_err_o;

  modport slave (
    input  wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i,
    output wb_dat_o, wb_ack_o, wb_err_o
  );

  modport master (
    output wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i,
    input  wb_dat_o, wb_ack_o, wb_err_o
  );
endinterface

// File: rtl/wb_slave_regs_irq.sv
// Sticky interrupt status (W1C), interrupt mask and the registered interrupt line.
module wb_irq_ctrl
  import wb_slave_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int NUM_IRQ = 8
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic                wr_status_i,
  input  logic                wr_mask_i,
  input  logic [DATA_W/8-1:0] sel_i,
  input  logic [DATA_W-1:0]   dat_i,
  input  logic [NUM_IRQ-1:0]  evt_i,
  output logic [NUM_IRQ-1:0]  status_o,
  output logic [NUM_IRQ-1:0]  mask_o,
  output logic                int_o
);

  logic [NUM_IRQ-1:0] status_q, status_d;
  logic [NUM_IRQ-1:0] mask_q, mask_d;
  logic               int_q;
  logic [DATA_W-1:0]  clr_bytes, mask_bytes;
  logic               unused_hi;

  assign clr_bytes  = DATA_W'(apply_sel('0, WORD_MAX_W'(dat_i), SEL_MAX_W'(sel_i)));
  assign mask_bytes = DATA_W'(apply_sel(WORD_MAX_W'(mask_q), WORD_MAX_W'(dat_i),
                                        SEL_MAX_W'(sel_i)));
  assign unused_hi  = ^{clr_bytes, mask_bytes};

  // A new event in the same cycle as a clear keeps the bit set.
  always_comb begin
    status_d = evt_i | (status_q & ~(wr_status_i ? clr_bytes[NUM_IRQ-1:0] : '0));
    mask_d   = wr_mask_i ? mask_bytes[NUM_IRQ-1:0] : mask_q;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      status_q <= '0;
      mask_q   <= '0;
      int_q    <= 1'b0;
    end else begin
      status_q <= status_d;
      mask_q   <= mask_d;
      int_q    <= |(status_q & mask_q);
    end
  end

  assign status_o = status_q;
  assign mask_o   = mask_q;
  assign int_o    = int_q;

endmodule

// File: rtl/wb_slave_regs.sv
// Wishbone B3 classic configuration/status register slave with wait states,
// error termination for unmapped words and a maskable sticky interrupt.
module wb_slave_regs
  import wb_slave_pkg::*;
#(
  parameter int          ADDR_W      = 8,
  parameter int          DATA_W      = 32,
  parameter int          NUM_REGS    = 8,
  parameter int          NUM_IRQ     = 8,
  parameter int          WAIT_STATES = 0,
  parameter logic [31:0] ID_VALUE    = 32'h5847_0001
) (
  input  logic                             wb_clk_i,
  input  logic                             wb_rst_n_i,
  wb_slave_regs_if.slave                   wb,
  input  logic [NUM_IRQ-1:0]               evt_i,
  output logic                             wb_int_o,
  output logic [DATA_W-1:0]                ctrl_o,
  output logic [(NUM_REGS-4)*DATA_W-1:0]   cfg_o
);

  localparam int          IDX_W   = ADDR_W - 2;
  localparam int          NUM_GEN = NUM_REGS - REG_GEN_BASE;
  localparam logic [3:0]  WS_M1   = 4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

  wb_state_e           state_q;
  logic [3:0]          cnt_q;
  logic [IDX_W-1:0]    idx_q;
  logic [DATA_W-1:0]   dat_q;
  logic [DATA_W/8-1:0] sel_q;
  logic                we_q, oor_q, ack_q, err_q;

  logic [DATA_W-1:0]   ctrl_q;
  logic [DATA_W-1:0]   gen_q [NUM_GEN];
  logic [NUM_IRQ-1:0]  status, mask;
  logic [DATA_W-1:0]   rdata;
  logic [IDX_W-1:0]    idx_in;
  logic                oor_in, wr_en, unused_adr_lsb;

  assign idx_in         = wb.wb_adr_i[ADDR_W-1:2];
  assign oor_in         = int'(idx_in) >= NUM_REGS;
  assign unused_adr_lsb = ^wb.wb_adr_i[1:0];

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      dat_q   <= '0;
      sel_q   <= '0;
      we_q    <= 1'b0;
      oor_q   <= 1'b0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      ack_q <= 1'b0;
      err_q <= 1'b0;
      case (state_q)
        IDLE: if (wb.wb_cyc_i && wb.wb_stb_i) begin
          idx_q <= idx_in;
          dat_q <= wb.wb_dat_i;
          sel_q <= wb.wb_sel_i;
          we_q  <= wb.wb_we_i;
          oor_q <= oor_in;
          if (WAIT_STATES > 0) begin
            state_q <= WAIT;
            cnt_q   <= WS_M1;
          end else begin
            state_q <= RESP;
            ack_q   <= !oor_in;
            err_q   <= oor_in;
          end
        end
        WAIT: begin
          if (!wb.wb_cyc_i) begin
            state_q <= IDLE;
          end else if (cnt_q == '0) begin
            state_q <= RESP;
            ack_q   <= !oor_q;
            err_q   <= oor_q;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        RESP:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // ack_q/err_q are only ever high in RESP; gating with cyc turns a master
  // abort during RESP into a silent return with no side effects.
  assign wb.wb_ack_o = ack_q & wb.wb_cyc_i;
  assign wb.wb_err_o = err_q & wb.wb_cyc_i;
  assign wr_en       = wb.wb_ack_o & we_q;

  function automatic logic [DATA_W-1:0] merge_w(input logic [DATA_W-1:0] old_v);
    return DATA_W'(apply_sel(WORD_MAX_W'(old_v), WORD_MAX_W'(dat_q), SEL_MAX_W'(sel_q)));
  endfunction

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      ctrl_q <= '0;
      for (int unsigned i = 0; i < NUM_GEN; i++) gen_q[i] <= '0;
    end else if (wr_en) begin
      if (idx_q == IDX_W'(REG_CTRL)) ctrl_q <= merge_w(ctrl_q);
      for (int unsigned i = 0; i < NUM_GEN; i++) begin
        if (idx_q == IDX_W'(REG_GEN_BASE + i)) gen_q[i] <= merge_w(gen_q[i]);
      end
    end
  end

  wb_irq_ctrl #(
    .DATA_W (DATA_W),
    .NUM_IRQ(NUM_IRQ)
  ) u_irq (
    .clk_i      (wb_clk_i),
    .rst_n_i    (wb_rst_n_i),
    .wr_status_i(wr_en && (idx_q == IDX_W'(REG_INT_STATUS))),
    .wr_mask_i  (wr_en && (idx_q == IDX_W'(REG_INT_MASK))),
    .sel_i      (sel_q),
    .dat_i      (dat_q),
    .evt_i      (evt_i),
    .status_o   (status),
    .mask_o     (mask),
    .int_o      (wb_int_o)
  );

  always_comb begin
    rdata = '0;
    if (idx_q == IDX_W'(REG_CTRL))       rdata = ctrl_q;
    if (idx_q == IDX_W'(REG_INT_STATUS)) rdata = DATA_W'(status);
    if (idx_q == IDX_W'(REG_INT_MASK))   rdata = DATA_W'(mask);
    if (idx_q == IDX_W'(REG_ID))         rdata = DATA_W'(ID_VALUE);
    for (int unsigned i = 0; i < NUM_GEN; i++) begin
      if (idx_q == IDX_W'(REG_GEN_BASE + i)) rdata = gen_q[i];
    end
  end

  assign wb.wb_dat_o = wb.wb_ack_o ? rdata : '0;
  assign ctrl_o      = ctrl_q;

  always_comb begin
    cfg_o = '0;
    for (int unsigned i = 0; i < NUM_GEN; i++) cfg_o[i*DATA_W +: DATA_W] = gen_q[i];
  end

endmodule
